// File: rtl/mem_requester.sv
// ---------------------------------------------------------------------------
// mem_requester
//
// Turns a single-cycle load/store request from the pipeline into a held
// request/acknowledge handshake with a memory responder. The pipeline is
// stalled (freeze) while the access is outstanding. A one-cycle done pulse
// marks completion. If the responder never acknowledges, the access is
// abandoned after TIMEOUT request cycles and a sticky error flag is raised.
//
// Parameters
//   BASE_ADDR : byte address that maps to data-memory word 0
//   TIMEOUT   : number of request cycles allowed before the access is aborted
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   alu_res  in   byte address from the execute stage
//   val_rm   in   store data
//   mem_w_en in   store request
//   mem_r_en in   load request (a store wins when both are set)
//   res_data out  last load result
//   freeze   out  pipeline stall (combinational)
//   done     out  one-cycle completion pulse
//   err      out  sticky timeout flag
//   m_req    out  request to the responder
//   m_we     out  request is a write
//   m_addr   out  word address
//   m_wdata  out  write data
//   m_ack    in   responder completion, only looked at while m_req is high
//   m_rdata  in   read data, valid together with m_ack
// ---------------------------------------------------------------------------
module mem_requester #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_rm,
    input  logic        mem_w_en,
    input  logic        mem_r_en,
    output logic [31:0] res_data,
    output logic        freeze,
    output logic        done,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_start;
    logic        w_ack_take;
    logic        w_timeout;
    logic        w_freeze;
    logic        w_cnt_last;
    logic [31:0] w_diff;
    logic [31:0] w_word_addr;

    logic        r_m_req;
    logic        r_m_we;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [31:0] r_res_data;
    logic        r_done;
    logic        r_err;
    logic [7:0]  r_cnt;

    // Offset from the base wraps mod 2^32; shifting right by two drops the
    // byte offset and leaves the top two bits zero.
    assign w_diff      = alu_res - BASE_ADDR;
    assign w_word_addr = w_diff >> 2;

    // This request cycle is the last one allowed without an acknowledge.
    assign w_cnt_last  = ({1'b0, r_cnt} + 9'd1) >= {1'b0, TIMEOUT};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, handshake events and the combinational stall.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_ack_take = 1'b0;
        w_timeout  = 1'b0;
        w_freeze   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_w_en || mem_r_en) begin
                    w_next   = ST_REQ;
                    w_start  = 1'b1;
                    w_freeze = 1'b1;
                end else begin
                    w_next   = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_freeze = 1'b1;
                // An acknowledge in the final allowed cycle still counts.
                if (m_ack) begin
                    w_next     = ST_DONE;
                    w_ack_take = 1'b1;
                end else if (w_cnt_last) begin
                    w_next    = ST_DONE;
                    w_timeout = 1'b1;
                end else begin
                    w_next = ST_REQ;
                end
            end
            ST_DONE: begin
                // Enables still held here must not launch another access.
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request outputs, wait counter, load result and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= 32'd0;
            r_m_wdata  <= 32'd0;
            r_res_data <= 32'd0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            // Decoded from the next state so both flags line up with the state.
            r_m_req <= (w_next == ST_REQ);
            r_done  <= (w_next == ST_DONE);

            // Request fields only change on a new access, so they stay
            // stable for the whole request phase.
            if (w_start) begin
                r_m_we    <= mem_w_en;
                r_m_addr  <= w_word_addr;
                r_m_wdata <= val_rm;
                r_cnt     <= 8'd0;
            end else if ((r_state == ST_REQ) && !m_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            // Writes never touch the load result.
            if (w_ack_take && !r_m_we) begin
                r_res_data <= m_rdata;
            end else if (w_timeout && !r_m_we) begin
                r_res_data <= 32'd0;
            end else begin
                r_res_data <= r_res_data;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign freeze   = w_freeze;
    assign done     = r_done;
    assign err      = r_err;
    assign m_req    = r_m_req;
    assign m_we     = r_m_we;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign res_data = r_res_data;

endmodule
